// File: rtl/wb_timer_pkg.sv
// Shared constants for the wb_timer peripheral: register word offsets,
// CTRL bit positions, reset values and a byte-lane merge helper.
package wb_timer_pkg;

  localparam int PRESC_WIDTH_DEF = 16;

  // Register word selects (byte offset / 4)
  localparam logic [2:0] REG_CTRL     = 3'd0;
  localparam logic [2:0] REG_PRESCALE = 3'd1;
  localparam logic [2:0] REG_COUNT    = 3'd2;
  localparam logic [2:0] REG_COMPARE  = 3'd3;
  localparam logic [2:0] REG_STATUS   = 3'd4;

  // CTRL bit positions
  localparam int CTRL_EN    = 0;
  localparam int CTRL_AR    = 1;
  localparam int CTRL_IE    = 2;
  localparam int CTRL_WIDTH = 3;

  localparam logic [31:0] COMPARE_RST = 32'hFFFF_FFFF;

  // Merge new_val into old_val on the byte lanes selected by be
  function automatic logic [31:0] apply_byte_en(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  be);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) begin
        res[8*i +: 8] = new_val[8*i +: 8];
      end else begin
        res[8*i +: 8] = old_val[8*i +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/wb_timer_prescaler.sv
// Prescaler for wb_timer: counts 0..prescale_i while enabled and flags a
// tick on the terminal value. Held at zero while disabled so that enabling
// gives the first tick prescale_i+1 cycles later. A counter already above a
// newly written smaller prescale runs up to its maximum and wraps to zero.
module timer_prescaler
  import wb_timer_pkg::*;
#(
  parameter int PRESC_WIDTH = PRESC_WIDTH_DEF
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   en_i,
  input  logic [PRESC_WIDTH-1:0] prescale_i,
  output logic                   tick_o
);

  logic [PRESC_WIDTH-1:0] cnt_r;
  logic [PRESC_WIDTH-1:0] cnt_nxt_s;
  logic                   tick_s;

  // Tick decode and next prescaler count
  always_comb begin
    tick_s    = en_i && (cnt_r == prescale_i);
    cnt_nxt_s = cnt_r;
    if (!en_i) begin
      cnt_nxt_s = {PRESC_WIDTH{1'b0}};
    end else if (tick_s) begin
      cnt_nxt_s = {PRESC_WIDTH{1'b0}};
    end else begin
      cnt_nxt_s = cnt_r + PRESC_WIDTH'(1);
    end
  end

  // Prescaler count register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_r <= {PRESC_WIDTH{1'b0}};
    end else begin
      cnt_r <= cnt_nxt_s;
    end
  end

  assign tick_o = tick_s;

endmodule

// File: rtl/wb_timer.sv
// Wishbone timer/compare peripheral: prescaled 32-bit up-counter, 32-bit
// compare, sticky match flag and level interrupt. Single-cycle ack; every
// output comes straight from a register.
module wb_timer
  import wb_timer_pkg::*;
#(
  parameter int PRESC_WIDTH = PRESC_WIDTH_DEF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] wb_addr_i,
  input  logic [31:0] wb_wdata_i,
  output logic [31:0] wb_rdata_o,
  input  logic        wb_wr_en_i,
  input  logic [3:0]  wb_byte_en_i,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  output logic        wb_ack_o,
  output logic        irq_o
);

  logic [CTRL_WIDTH-1:0]  ctrl_r,     ctrl_nxt_s;
  logic [PRESC_WIDTH-1:0] prescale_r, prescale_nxt_s;
  logic [31:0]            count_r,    count_nxt_s;
  logic [31:0]            compare_r,  compare_nxt_s;
  logic                   match_r,    match_nxt_s;
  logic                   ack_r;
  logic [31:0]            rdata_r,    rdata_nxt_s;
  logic                   irq_r,      irq_nxt_s;

  logic        req_s, wr_s, rd_s, tick_s, match_hit_s;
  logic        count_wr_s, w1c_s;
  logic [2:0]  word_s;
  logic [31:0] ctrl_merge_s, presc_merge_s, count_merge_s, compare_merge_s;
  logic        unused_s;

  assign req_s  = wb_cyc_i && wb_stb_i && !ack_r;
  assign wr_s   = req_s && wb_wr_en_i;
  assign rd_s   = req_s && !wb_wr_en_i;
  assign word_s = wb_addr_i[4:2];

  assign ctrl_merge_s    = apply_byte_en(32'(ctrl_r), wb_wdata_i, wb_byte_en_i);
  assign presc_merge_s   = apply_byte_en(32'(prescale_r), wb_wdata_i, wb_byte_en_i);
  assign count_merge_s   = apply_byte_en(count_r, wb_wdata_i, wb_byte_en_i);
  assign compare_merge_s = apply_byte_en(compare_r, wb_wdata_i, wb_byte_en_i);

  // Address bits outside the word select and merge bits above each register width
  assign unused_s = ^{wb_addr_i[31:5], wb_addr_i[1:0],
                      ctrl_merge_s[31:CTRL_WIDTH], presc_merge_s[31:PRESC_WIDTH]};

  timer_prescaler #(
    .PRESC_WIDTH (PRESC_WIDTH)
  ) u_prescaler (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .en_i       (ctrl_r[CTRL_EN]),
    .prescale_i (prescale_r),
    .tick_o     (tick_s)
  );

  // Register writes, read mux, counter/compare update and interrupt next-state
  always_comb begin
    ctrl_nxt_s     = ctrl_r;
    prescale_nxt_s = prescale_r;
    compare_nxt_s  = compare_r;
    count_wr_s     = 1'b0;
    w1c_s          = 1'b0;
    rdata_nxt_s    = 32'h0000_0000;

    if (wr_s) begin
      case (word_s)
        REG_CTRL:     ctrl_nxt_s     = ctrl_merge_s[CTRL_WIDTH-1:0];
        REG_PRESCALE: prescale_nxt_s = presc_merge_s[PRESC_WIDTH-1:0];
        REG_COUNT:    count_wr_s     = 1'b1;
        REG_COMPARE:  compare_nxt_s  = compare_merge_s;
        REG_STATUS:   w1c_s          = wb_byte_en_i[0] && wb_wdata_i[0];
        default:      w1c_s          = 1'b0;
      endcase
    end else begin
      w1c_s = 1'b0;
    end

    if (rd_s) begin
      case (word_s)
        REG_CTRL:     rdata_nxt_s = 32'(ctrl_r);
        REG_PRESCALE: rdata_nxt_s = 32'(prescale_r);
        REG_COUNT:    rdata_nxt_s = count_r;
        REG_COMPARE:  rdata_nxt_s = compare_r;
        REG_STATUS:   rdata_nxt_s = {31'h0000_0000, match_r};
        default:      rdata_nxt_s = 32'h0000_0000;
      endcase
    end else begin
      rdata_nxt_s = 32'h0000_0000;
    end

    // A software COUNT write overrides the tick in the same cycle
    match_hit_s = tick_s && (count_r == compare_r);
    if (count_wr_s) begin
      count_nxt_s = count_merge_s;
    end else if (match_hit_s && ctrl_r[CTRL_AR]) begin
      count_nxt_s = 32'h0000_0000;
    end else if (tick_s) begin
      count_nxt_s = count_r + 32'h0000_0001;
    end else begin
      count_nxt_s = count_r;
    end

    // A new match beats a simultaneous write-1-to-clear
    if (match_hit_s) begin
      match_nxt_s = 1'b1;
    end else if (w1c_s) begin
      match_nxt_s = 1'b0;
    end else begin
      match_nxt_s = match_r;
    end

    // Registered from next state so irq follows the flag/enable without a lag cycle
    irq_nxt_s = match_nxt_s && ctrl_nxt_s[CTRL_IE];
  end

  // State and bus output registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ctrl_r     <= {CTRL_WIDTH{1'b0}};
      prescale_r <= {PRESC_WIDTH{1'b0}};
      count_r    <= 32'h0000_0000;
      compare_r  <= COMPARE_RST;
      match_r    <= 1'b0;
      ack_r      <= 1'b0;
      rdata_r    <= 32'h0000_0000;
      irq_r      <= 1'b0;
    end else begin
      ctrl_r     <= ctrl_nxt_s;
      prescale_r <= prescale_nxt_s;
      count_r    <= count_nxt_s;
      compare_r  <= compare_nxt_s;
      match_r    <= match_nxt_s;
      ack_r      <= req_s;
      rdata_r    <= rdata_nxt_s;
      irq_r      <= irq_nxt_s;
    end
  end

  assign wb_ack_o   = ack_r;
  assign wb_rdata_o = rdata_r;
  assign irq_o      = irq_r;

endmodule
